// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritises memory wait, trap, multi-cycle MDU,
// branch redirect and load-use hazards into per-stage stall/flush controls.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int unsigned RAW  = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  rs1_idx,
    input  logic [RAW-1:0]  rs2_idx,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [RAW-1:0]  ex_rd_idx,
    input  logic            ex_is_load,
    input  logic            ex_mdu_start,
    input  logic            mdu_done,
    input  logic            ls_req,
    input  logic            ls_ready,
    input  logic            br_taken,
    input  logic            trap_req,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            idex_stall,
    output logic            exls_stall,
    output logic            lswb_stall,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exls_flush,
    output logic            lswb_flush,
    output logic            mdu_kill,
    output logic            trap_redirect,
    output logic [1:0]      state,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MDU  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    localparam int unsigned NSTALL = 5;
    localparam int unsigned NFLUSH = 4;

    state_e            state_q, state_d;
    logic              trap_redirect_q, trap_redirect_d;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]   flush_cnt_q, flush_cnt_d;

    // {pc, ifid, idex, exls, lswb} and {ifid, idex, exls, lswb}
    logic [NSTALL-1:0] stall_c;
    logic [NFLUSH-1:0] flush_c;
    logic              kill_c;
    logic              mem_wait_c;
    logic              load_use_c;

    always_comb begin
        mem_wait_c = ls_req & ~ls_ready;
        load_use_c = ex_is_load & (ex_rd_idx != '0) &
                     ((rs1_used & (rs1_idx == ex_rd_idx)) |
                      (rs2_used & (rs2_idx == ex_rd_idx)));
    end

    // Next-state and hazard decode; memory wait freezes everything, including a pending trap.
    always_comb begin
        state_d = state_q;
        stall_c = '0;
        flush_c = '0;
        kill_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait_c) begin
                    stall_c = 5'b11111;
                end else if (trap_req) begin
                    flush_c = 4'b1110;
                    state_d = ST_TRAP;
                end else if (ex_mdu_start) begin
                    stall_c = 5'b11100;
                    flush_c = 4'b0010;
                    state_d = ST_MDU;
                end else if (br_taken) begin
                    flush_c = 4'b1100;
                end else if (load_use_c) begin
                    stall_c = 5'b11000;
                    flush_c = 4'b0100;
                end
            end
            ST_MDU: begin
                if (mem_wait_c) begin
                    stall_c = 5'b11111;
                end else if (trap_req) begin
                    flush_c = 4'b1110;
                    kill_c  = 1'b1;
                    state_d = ST_TRAP;
                end else if (mdu_done) begin
                    state_d = ST_RUN;
                end else begin
                    // Front end holds while the bubble drains LS/WB behind the MDU op.
                    stall_c = 5'b11100;
                    flush_c = 4'b0010;
                end
            end
            ST_TRAP: begin
                if (mem_wait_c) begin
                    stall_c = 5'b11111;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Counters saturate at all-ones; trap_redirect tracks the TRAP state.
    always_comb begin
        trap_redirect_d = (state_d == ST_TRAP);
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (stall_c[4] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
        if ((flush_c != '0) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            trap_redirect_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            trap_redirect_q <= trap_redirect_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    // Combinational controls are forced quiet while reset is asserted.
    always_comb begin
        {pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall} = rst_n ? stall_c : '0;
        {ifid_flush, idex_flush, exls_flush, lswb_flush}           = rst_n ? flush_c : '0;
        mdu_kill = rst_n & kill_c;
    end

    assign trap_redirect = trap_redirect_q;
    assign state         = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters make saturation reachable.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int unsigned RAW  = 5;
    localparam int unsigned CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [RAW-1:0]  rs1_idx, rs2_idx, ex_rd_idx;
    logic            rs1_used, rs2_used, ex_is_load, ex_mdu_start, mdu_done;
    logic            ls_req, ls_ready, br_taken, trap_req;
    logic            pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall;
    logic            ifid_flush, idex_flush, exls_flush, lswb_flush;
    logic            mdu_kill, trap_redirect;
    logic [1:0]      state;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RAW(RAW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .ex_rd_idx(ex_rd_idx), .ex_is_load(ex_is_load),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ls_req(ls_req), .ls_ready(ls_ready),
        .br_taken(br_taken), .trap_req(trap_req),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exls_stall(exls_stall), .lswb_stall(lswb_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exls_flush(exls_flush), .lswb_flush(lswb_flush),
        .mdu_kill(mdu_kill), .trap_redirect(trap_redirect),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] st, input logic [3:0] fl);
        chk({tag, ".stall"}, 32'({pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall}), 32'(st));
        chk({tag, ".flush"}, 32'({ifid_flush, idex_flush, exls_flush, lswb_flush}), 32'(fl));
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(s));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(f));
    endtask

    task automatic clr();
        rs1_idx = '0; rs2_idx = '0; ex_rd_idx = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; ex_is_load = 1'b0;
        ex_mdu_start = 1'b0; mdu_done = 1'b0;
        ls_req = 1'b0; ls_ready = 1'b0; br_taken = 1'b0; trap_req = 1'b0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        // hazards driven during reset must not reach the outputs
        ls_req = 1'b1; br_taken = 1'b1; trap_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.redirect", 32'(trap_redirect), 32'd0);
        chk("rst.kill", 32'(mdu_kill), 32'd0);
        chk_ctl("rst", 5'b00000, 4'b0000);
        chk_cnt("rst", 0, 0);
        @(negedge clk); clr(); rst_n = 1'b1;

        // load x5 in EX, ID reads x5 via rs1
        @(negedge clk);
        ex_is_load = 1'b1; ex_rd_idx = 5'd5; rs1_used = 1'b1; rs1_idx = 5'd5;
        #1 chk_ctl("lu_rs1", 5'b11000, 4'b0100);
        @(negedge clk); clr();
        #1 chk_ctl("lu_after", 5'b00000, 4'b0000);
        chk_cnt("lu_after", 1, 1);

        // rs2 match; then same index but rs2 not used
        @(negedge clk);
        ex_is_load = 1'b1; ex_rd_idx = 5'd7; rs1_used = 1'b1; rs1_idx = 5'd3;
        rs2_used = 1'b1; rs2_idx = 5'd7;
        #1 chk_ctl("lu_rs2", 5'b11000, 4'b0100);
        @(negedge clk); rs2_used = 1'b0;
        #1 chk_ctl("lu_rs2_unused", 5'b00000, 4'b0000);

        // load to x0 never stalls
        @(negedge clk); clr();
        ex_is_load = 1'b1; ex_rd_idx = 5'd0; rs1_used = 1'b1; rs1_idx = 5'd0;
        #1 chk_ctl("lu_x0", 5'b00000, 4'b0000);

        // branch beats load-use
        @(negedge clk); clr();
        ex_is_load = 1'b1; ex_rd_idx = 5'd9; rs1_used = 1'b1; rs1_idx = 5'd9; br_taken = 1'b1;
        #1 chk_ctl("br_lu", 5'b00000, 4'b1100);
        @(negedge clk); clr();
        #1 chk_cnt("br_lu", 2, 3);

        // reset pulse clears counters before the MDU sequence
        @(negedge clk); rst_n = 1'b0;
        #1 chk_cnt("rst2", 0, 0);
        @(negedge clk); rst_n = 1'b1;

        // MDU: entry cycle plus three busy cycles, done on the fourth
        @(negedge clk); ex_mdu_start = 1'b1;
        #1 chk("mdu_entry.state", 32'(state), 32'd0);
        chk_ctl("mdu_entry", 5'b11100, 4'b0010);
        @(negedge clk); ex_mdu_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mdu_busy.state", 32'(state), 32'd1);
            chk_ctl("mdu_busy", 5'b11100, 4'b0010);
            @(negedge clk);
        end
        mdu_done = 1'b1;
        #1 chk("mdu_done.state", 32'(state), 32'd1);
        chk_ctl("mdu_done", 5'b00000, 4'b0000);
        chk_cnt("mdu_done", 4, 4);
        @(negedge clk);
        #1 chk("mdu_exit.state", 32'(state), 32'd0);
        chk_ctl("done_in_run", 5'b00000, 4'b0000);
        @(negedge clk); mdu_done = 1'b0;
        #1 chk("done_ignored.state", 32'(state), 32'd0);

        // memory wait holds a branch and swallows a trap
        @(negedge clk); ls_req = 1'b1; ls_ready = 1'b0; br_taken = 1'b1;
        #1 chk_ctl("mw1", 5'b11111, 4'b0000);
        @(negedge clk); trap_req = 1'b1;
        #1 chk_ctl("mw2_trap", 5'b11111, 4'b0000);
        chk("mw2.kill", 32'(mdu_kill), 32'd0);
        @(negedge clk); trap_req = 1'b0;
        #1 chk("mw3.state", 32'(state), 32'd0);
        chk_ctl("mw3", 5'b11111, 4'b0000);
        @(negedge clk); ls_ready = 1'b1;
        #1 chk_ctl("mw_release_br", 5'b00000, 4'b1100);
        @(negedge clk); clr();
        #1 chk_cnt("mw", 7, 5);

        // trap during MDU
        @(negedge clk); ex_mdu_start = 1'b1;
        @(negedge clk); ex_mdu_start = 1'b0; trap_req = 1'b1;
        #1 chk("trap_mdu.state", 32'(state), 32'd1);
        chk("trap_mdu.kill", 32'(mdu_kill), 32'd1);
        chk_ctl("trap_mdu", 5'b00000, 4'b1110);
        @(negedge clk); trap_req = 1'b0;
        #1 chk("trap_st.state", 32'(state), 32'd2);
        chk("trap_st.redirect", 32'(trap_redirect), 32'd1);
        chk("trap_st.kill", 32'(mdu_kill), 32'd0);
        chk_ctl("trap_st", 5'b00000, 4'b0000);
        @(negedge clk);
        #1 chk("trap_out.state", 32'(state), 32'd0);
        chk("trap_out.redirect", 32'(trap_redirect), 32'd0);
        chk_cnt("trap_mdu", 8, 7);

        // trap from RUN: no kill
        @(negedge clk); trap_req = 1'b1;
        #1 chk("trap_run.kill", 32'(mdu_kill), 32'd0);
        chk_ctl("trap_run", 5'b00000, 4'b1110);
        @(negedge clk); trap_req = 1'b0;
        #1 chk("trap_run2.state", 32'(state), 32'd2);
        @(negedge clk);
        #1 chk("trap_run3.state", 32'(state), 32'd0);

        // saturation: 6 stalls -> 14, 3 more -> held at 15
        @(negedge clk); ls_req = 1'b1;
        repeat (6) @(negedge clk);
        #1 chk("sat_m1.stall_cnt", 32'(stall_cnt), 32'd14);
        repeat (3) @(negedge clk);
        #1 chk("sat.stall_cnt", 32'(stall_cnt), 32'd15);
        @(negedge clk); clr(); br_taken = 1'b1;
        repeat (10) @(negedge clk);
        #1 chk("sat.flush_cnt", 32'(flush_cnt), 32'd15);
        clr();

        // reset mid-MDU abandons it immediately
        @(negedge clk); ex_mdu_start = 1'b1;
        @(negedge clk); ex_mdu_start = 1'b0;
        #1 chk("rmdu.state", 32'(state), 32'd1);
        @(negedge clk); rst_n = 1'b0; ls_req = 1'b1;
        #1 chk("rmdu_rst.state", 32'(state), 32'd0);
        chk_ctl("rmdu_rst", 5'b00000, 4'b0000);
        chk_cnt("rmdu_rst", 0, 0);
        @(negedge clk); clr(); rst_n = 1'b1;
        #1 chk("rmdu_rel.state", 32'(state), 32'd0);
        @(negedge clk);
        #1 chk("rmdu_run.state", 32'(state), 32'd0);
        chk_ctl("rmdu_run", 5'b00000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
